// File: rtl/noc_traffic_node.sv
// noc_traffic_node: NoC traffic generator/sink with 2-phase req/ack links.
// TX issues bursts of packets {dest, seq}; RX acks every packet, counts it,
// and flags packets whose header differs from my_addr.
// Optional macro NOC_TRAFFIC_SYNC_EN: 2-flop synchronisers on ack_i and req_i.
// Ports:
//   clk, rst (sync, active-low)
//   start, mode, fixed_dst, pkt_count, gap, my_addr  - burst control
//   req_o, data_o, ack_i                             - TX link
//   req_i, data_i, ack_o                             - RX link
//   busy, done, tx_cnt, rx_cnt, err_cnt, last_rx     - status
module noc_traffic_node #(
  parameter int unsigned PAYLOAD = 32,
  parameter int unsigned X_BITS  = 1,
  parameter int unsigned Y_BITS  = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [1:0]                         mode,
  input  logic [X_BITS+Y_BITS-1:0]           fixed_dst,
  input  logic [CNT_W-1:0]                   pkt_count,
  input  logic [7:0]                         gap,
  input  logic [X_BITS+Y_BITS-1:0]           my_addr,
  output logic                               req_o,
  output logic [X_BITS+Y_BITS+PAYLOAD-1:0]   data_o,
  input  logic                               ack_i,
  input  logic                               req_i,
  input  logic [X_BITS+Y_BITS+PAYLOAD-1:0]   data_i,
  output logic                               ack_o,
  output logic                               busy,
  output logic                               done,
  output logic [CNT_W-1:0]                   tx_cnt,
  output logic [CNT_W-1:0]                   rx_cnt,
  output logic [CNT_W-1:0]                   err_cnt,
  output logic [X_BITS+Y_BITS+PAYLOAD-1:0]   last_rx
);

  localparam int unsigned A_W   = X_BITS + Y_BITS;
  localparam int unsigned PKT_W = A_W + PAYLOAD;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, GAP} tx_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Handshake inputs, optionally synchronised
  logic ack_s, req_s;
`ifdef NOC_TRAFFIC_SYNC_EN
  logic [1:0] ack_sync, req_sync;
  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_sync <= '0;
      req_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[0], ack_i};
      req_sync <= {req_sync[0], req_i};
    end
  end
  assign ack_s = ack_sync[1];
  assign req_s = req_sync[1];
`else
  assign ack_s = ack_i;
  assign req_s = req_i;
`endif

  // TX state and burst context
  tx_state_t        state, state_nxt;
  logic [CNT_W-1:0] burst_len, burst_len_nxt;
  logic [CNT_W-1:0] seq, seq_nxt, seq_inc;
  logic [7:0]       gap_len, gap_len_nxt;
  logic [7:0]       gap_cnt, gap_cnt_nxt;
  logic [1:0]       mode_q, mode_nxt;
  logic [A_W-1:0]   dst, dst_nxt, dest_sel;
  logic [15:0]      lfsr, lfsr_nxt;
  logic             lfsr_fb;
  logic             req_nxt, busy_nxt, done_nxt;
  logic [PKT_W-1:0] data_nxt;
  logic [CNT_W-1:0] tx_cnt_nxt;

  assign seq_inc = seq + CNT_W'(1);
  // Right-shift Fibonacci form of taps 16,14,13,11
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  // dst only advances in mode 01, so it equals fixed_dst for modes 00/11
  assign dest_sel = (mode_q == 2'b10) ? A_W'(lfsr) : dst;

  // Next-state and registered-output logic
  always_comb begin
    state_nxt     = state;
    burst_len_nxt = burst_len;
    seq_nxt       = seq;
    gap_len_nxt   = gap_len;
    gap_cnt_nxt   = gap_cnt;
    mode_nxt      = mode_q;
    dst_nxt       = dst;
    lfsr_nxt      = lfsr;
    req_nxt       = req_o;
    data_nxt      = data_o;
    tx_cnt_nxt    = tx_cnt;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (pkt_count != '0) begin
            state_nxt     = SEND;
            burst_len_nxt = pkt_count;
            gap_len_nxt   = gap;
            mode_nxt      = mode;
            dst_nxt       = fixed_dst;
            seq_nxt       = '0;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      SEND: begin
        data_nxt  = {dest_sel, PAYLOAD'(seq)};
        req_nxt   = ~req_o;
        lfsr_nxt  = {lfsr_fb, lfsr[15:1]};
        if (mode_q == 2'b01) dst_nxt = dst + A_W'(1);
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_s == req_o) begin
          tx_cnt_nxt = sat_inc(tx_cnt);
          seq_nxt    = seq_inc;
          if (seq_inc == burst_len) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else if (gap_len == 8'd0) begin
            state_nxt = SEND;
          end else begin
            state_nxt   = GAP;
            gap_cnt_nxt = gap_len;
          end
        end
      end
      GAP: begin
        if (gap_cnt == 8'd1) state_nxt = SEND;
        else gap_cnt_nxt = gap_cnt - 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // TX registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      burst_len <= '0;
      seq       <= '0;
      gap_len   <= '0;
      gap_cnt   <= '0;
      mode_q    <= '0;
      dst       <= '0;
      lfsr      <= LFSR_SEED;
      req_o     <= 1'b0;
      data_o    <= '0;
      tx_cnt    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      burst_len <= burst_len_nxt;
      seq       <= seq_nxt;
      gap_len   <= gap_len_nxt;
      gap_cnt   <= gap_cnt_nxt;
      mode_q    <= mode_nxt;
      dst       <= dst_nxt;
      lfsr      <= lfsr_nxt;
      req_o     <= req_nxt;
      data_o    <= data_nxt;
      tx_cnt    <= tx_cnt_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  // RX: a pending request (req level != ack level) is accepted in one cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_o   <= 1'b0;
      last_rx <= '0;
      rx_cnt  <= '0;
      err_cnt <= '0;
    end else if (req_s != ack_o) begin
      ack_o   <= ~ack_o;
      last_rx <= data_i;
      rx_cnt  <= sat_inc(rx_cnt);
      if (data_i[PKT_W-1 -: A_W] != my_addr) err_cnt <= sat_inc(err_cnt);
    end
  end

endmodule

// File: tb/tb_noc_traffic_node.sv
// Directed bench for noc_traffic_node: loopback bursts, destination modes,
// gap timing, zero-length and ignored starts, mid-burst reset, RX latency.
module tb_noc_traffic_node;
  localparam int unsigned PKT_W = 34;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       mode = '0;
  logic [1:0]       fixed_dst = '0;
  logic [CNT_W-1:0] pkt_count = '0;
  logic [7:0]       gap = '0;
  logic [1:0]       my_addr = '0;
  logic             req_o, ack_o, busy, done;
  logic [PKT_W-1:0] data_o, last_rx;
  logic [CNT_W-1:0] tx_cnt, rx_cnt, err_cnt;
  logic             ack_i, req_i;
  logic [PKT_W-1:0] data_i;

  // loop=1 wires TX back into RX; loop=0 lets the bench act as the peer
  logic             loop = 1'b1;
  logic             tb_ack = 1'b0;
  logic             tb_req = 1'b0;
  logic [PKT_W-1:0] tb_data = '0;
  assign ack_i  = loop ? ack_o  : tb_ack;
  assign req_i  = loop ? req_o  : tb_req;
  assign data_i = loop ? data_o : tb_data;

  always #5 clk = ~clk;

  noc_traffic_node dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .fixed_dst(fixed_dst),
    .pkt_count(pkt_count), .gap(gap), .my_addr(my_addr),
    .req_o(req_o), .data_o(data_o), .ack_i(ack_i),
    .req_i(req_i), .data_i(data_i), .ack_o(ack_o),
    .busy(busy), .done(done), .tx_cnt(tx_cnt), .rx_cnt(rx_cnt),
    .err_cnt(err_cnt), .last_rx(last_rx)
  );

  int checks = 0;
  int errors = 0;
  logic [PKT_W-1:0] pkts[$];
  int n_done;
  bit saw_busy;

  // Launch a burst and record every packet seen on req_o toggles
  task automatic run_burst(input logic [1:0] m, input logic [1:0] fd,
                           input logic [15:0] n, input logic [7:0] g,
                           input int restart_at);
    logic prev_req;
    int tail;
    pkts.delete();
    n_done = 0; saw_busy = 0; tail = 0;
    prev_req = req_o;
    mode = m; fixed_dst = fd; pkt_count = n; gap = g; start = 1'b1;
    for (int c = 0; c < 400 && tail < 4; c++) begin
      @(posedge clk); #1;
      start = (c == restart_at);
      if (c == restart_at) pkt_count = 16'd5;
      if (busy) saw_busy = 1;
      if (req_o !== prev_req) begin pkts.push_back(data_o); prev_req = req_o; end
      if (done) n_done++;
      if (n_done > 0) tail++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_o !== 1'b0 || ack_o !== 1'b0) begin errors++; $display("FAIL reset_handshake req_o=%b ack_o=%b expected 0 0", req_o, ack_o); end
    checks++; if (data_o !== '0 || last_rx !== '0) begin errors++; $display("FAIL reset_data data_o=%h last_rx=%h expected 0 0", data_o, last_rx); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_status busy=%b done=%b expected 0 0", busy, done); end
    checks++; if (tx_cnt !== '0 || rx_cnt !== '0 || err_cnt !== '0) begin errors++; $display("FAIL reset_counters tx=%0d rx=%0d err=%0d expected 0 0 0", tx_cnt, rx_cnt, err_cnt); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Mode 10 straight after reset: LFSR states ACE1,5670,AB38,559C -> headers 01,00,00,00
  task automatic test_lfsr_dest();
    logic [1:0] hdr[4];
    hdr = '{2'b01, 2'b00, 2'b00, 2'b00};
    loop = 1'b1; my_addr = 2'b01;
    run_burst(2'b10, 2'b11, 16'd4, 8'd0, -1);
    checks++; if (pkts.size() != 4) begin errors++; $display("FAIL lfsr_count got %0d packets expected 4", pkts.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= pkts.size() || pkts[i] !== {hdr[i], 32'(i)}) begin
        errors++; $display("FAIL lfsr_pkt%0d got %h expected %h", i, (i < pkts.size()) ? pkts[i] : '0, {hdr[i], 32'(i)});
      end
    end
    checks++; if (tx_cnt !== 16'd4 || rx_cnt !== 16'd4 || err_cnt !== 16'd3) begin errors++; $display("FAIL lfsr_counters tx=%0d rx=%0d err=%0d expected 4 4 3", tx_cnt, rx_cnt, err_cnt); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL lfsr_done got %0d pulses expected 1", n_done); end
  endtask

  // Mode 00 loopback: 4 packets to own address, no new errors
  task automatic test_fixed_dest();
    loop = 1'b1; my_addr = 2'b01;
    run_burst(2'b00, 2'b01, 16'd4, 8'd0, -1);
    checks++; if (pkts.size() != 4) begin errors++; $display("FAIL fixed_count got %0d packets expected 4", pkts.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= pkts.size() || pkts[i] !== {2'b01, 32'(i)}) begin
        errors++; $display("FAIL fixed_pkt%0d got %h expected %h", i, (i < pkts.size()) ? pkts[i] : '0, {2'b01, 32'(i)});
      end
    end
    checks++; if (tx_cnt !== 16'd8 || rx_cnt !== 16'd8 || err_cnt !== 16'd3) begin errors++; $display("FAIL fixed_counters tx=%0d rx=%0d err=%0d expected 8 8 3", tx_cnt, rx_cnt, err_cnt); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL fixed_done got %0d pulses expected 1", n_done); end
  endtask

  // Mode 01 from 11: headers 11,00,01,10; three of them miss my_addr=00
  task automatic test_incr_dest();
    logic [1:0] hdr[4];
    hdr = '{2'b11, 2'b00, 2'b01, 2'b10};
    loop = 1'b1; my_addr = 2'b00;
    run_burst(2'b01, 2'b11, 16'd4, 8'd0, -1);
    checks++; if (pkts.size() != 4) begin errors++; $display("FAIL incr_count got %0d packets expected 4", pkts.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= pkts.size() || pkts[i] !== {hdr[i], 32'(i)}) begin
        errors++; $display("FAIL incr_pkt%0d got %h expected %h", i, (i < pkts.size()) ? pkts[i] : '0, {hdr[i], 32'(i)});
      end
    end
    checks++; if (tx_cnt !== 16'd12 || rx_cnt !== 16'd12 || err_cnt !== 16'd6) begin errors++; $display("FAIL incr_counters tx=%0d rx=%0d err=%0d expected 12 12 6", tx_cnt, rx_cnt, err_cnt); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL incr_done got %0d pulses expected 1", n_done); end
  endtask

  task automatic test_zero_count();
    loop = 1'b1; my_addr = 2'b01;
    run_burst(2'b00, 2'b01, 16'd0, 8'd0, -1);
    checks++; if (pkts.size() != 0) begin errors++; $display("FAIL zero_packets got %0d expected 0", pkts.size()); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL zero_done got %0d pulses expected 1", n_done); end
    checks++; if (saw_busy !== 1'b0) begin errors++; $display("FAIL zero_busy saw busy=%b expected 0", saw_busy); end
    checks++; if (tx_cnt !== 16'd12) begin errors++; $display("FAIL zero_tx tx=%0d expected 12", tx_cnt); end
  endtask

  // A second start (pkt_count=5) mid-burst must not change the 2-packet burst
  task automatic test_start_ignored();
    loop = 1'b1; my_addr = 2'b01;
    run_burst(2'b00, 2'b01, 16'd2, 8'd0, 1);
    checks++; if (pkts.size() != 2) begin errors++; $display("FAIL restart_packets got %0d expected 2", pkts.size()); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL restart_done got %0d pulses expected 1", n_done); end
    checks++; if (tx_cnt !== 16'd14 || rx_cnt !== 16'd14) begin errors++; $display("FAIL restart_counters tx=%0d rx=%0d expected 14 14", tx_cnt, rx_cnt); end
  endtask

  // gap=5 with a peer that acks one cycle after each request: 5 idle edges
  // strictly between the edge counting ack 0 and the edge toggling req 1
  task automatic test_gap();
    logic prev_req;
    logic [CNT_W-1:0] prev_tx;
    int ack_cyc, tog_cyc, n_tog;
    bit pend;
    tb_ack = req_o; tb_req = ack_o; tb_data = '0; loop = 1'b0;
    prev_req = req_o; prev_tx = tx_cnt;
    ack_cyc = -1; tog_cyc = -1; n_tog = 0; pend = 0; n_done = 0;
    mode = 2'b00; fixed_dst = 2'b01; pkt_count = 16'd2; gap = 8'd5; start = 1'b1;
    for (int c = 0; c < 200 && n_done == 0; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (pend) begin tb_ack = req_o; pend = 0; end
      if (req_o !== prev_req) begin
        prev_req = req_o; n_tog++; pend = 1;
        if (n_tog == 2) tog_cyc = c;
      end
      if (tx_cnt !== prev_tx) begin
        if (ack_cyc < 0) ack_cyc = c;
        prev_tx = tx_cnt;
      end
      if (done) n_done++;
    end
    checks++; if (n_tog != 2 || n_done != 1) begin errors++; $display("FAIL gap_burst toggles=%0d done=%0d expected 2 1", n_tog, n_done); end
    checks++; if (ack_cyc < 0 || tog_cyc < 0 || tog_cyc - ack_cyc - 1 != 5) begin errors++; $display("FAIL gap_idle got %0d idle cycles expected 5", tog_cyc - ack_cyc - 1); end
    checks++; if (tx_cnt !== 16'd16 || rx_cnt !== 16'd14) begin errors++; $display("FAIL gap_counters tx=%0d rx=%0d expected 16 14", tx_cnt, rx_cnt); end
    gap = 8'd0;
  endtask

  task automatic test_reset_mid_burst();
    logic prev_req;
    int n_tog;
    loop = 1'b1; my_addr = 2'b01;
    mode = 2'b10; fixed_dst = 2'b00; pkt_count = 16'd4; gap = 8'd0; start = 1'b1;
    prev_req = req_o; n_tog = 0; n_done = 0;
    for (int c = 0; c < 200 && n_tog < 3; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (req_o !== prev_req) begin n_tog++; prev_req = req_o; end
      if (done) n_done++;
    end
    checks++; if (n_tog != 3) begin errors++; $display("FAIL midrst_reach got %0d toggles expected 3", n_tog); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (req_o !== 1'b0 || ack_o !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_status req=%b ack=%b busy=%b done=%b expected 0 0 0 0", req_o, ack_o, busy, done); end
    checks++; if (data_o !== '0 || last_rx !== '0 || tx_cnt !== '0 || rx_cnt !== '0 || err_cnt !== '0) begin errors++; $display("FAIL midrst_regs data=%h last=%h tx=%0d rx=%0d err=%0d expected all 0", data_o, last_rx, tx_cnt, rx_cnt, err_cnt); end
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; if (done) n_done++; end
    checks++; if (n_done != 0) begin errors++; $display("FAIL midrst_nodone got %0d pulses expected 0", n_done); end
    run_burst(2'b10, 2'b00, 16'd1, 8'd0, -1);
    checks++; if (pkts.size() != 1 || pkts[0] !== {2'b01, 32'd0}) begin errors++; $display("FAIL midrst_restart got %0d packets first %h expected 1 %h", pkts.size(), (pkts.size() > 0) ? pkts[0] : '0, {2'b01, 32'd0}); end
    checks++; if (tx_cnt !== 16'd1 || rx_cnt !== 16'd1 || err_cnt !== 16'd0) begin errors++; $display("FAIL midrst_counters tx=%0d rx=%0d err=%0d expected 1 1 0", tx_cnt, rx_cnt, err_cnt); end
  endtask

  task automatic test_rx_latency();
    logic old_ack;
    int edges, exp_edges;
`ifdef NOC_TRAFFIC_SYNC_EN
    exp_edges = 3;
`else
    exp_edges = 1;
`endif
    tb_ack = req_o; tb_req = ack_o; tb_data = {2'b01, 32'h0000_1234}; loop = 1'b0;
    my_addr = 2'b01;
    @(posedge clk); #1;
    old_ack = ack_o; tb_req = ~ack_o; edges = 0;
    for (int c = 0; c < 20 && ack_o === old_ack; c++) begin
      @(posedge clk); #1;
      edges++;
    end
    checks++; if (ack_o === old_ack || edges != exp_edges) begin errors++; $display("FAIL rx_latency got %0d edges expected %0d", edges, exp_edges); end
    checks++; if (rx_cnt !== 16'd2 || err_cnt !== 16'd0) begin errors++; $display("FAIL rx_counters rx=%0d err=%0d expected 2 0", rx_cnt, err_cnt); end
    checks++; if (last_rx !== {2'b01, 32'h0000_1234}) begin errors++; $display("FAIL rx_last got %h expected %h", last_rx, {2'b01, 32'h0000_1234}); end
  endtask

  initial begin
    test_reset();
    test_lfsr_dest();
    test_fixed_dest();
    test_incr_dest();
    test_zero_count();
    test_start_ignored();
    test_gap();
    test_reset_mid_burst();
    test_rx_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/noc_traffic_node.md
NOC_TRAFFIC_NODE -- requirements
Module: noc_traffic_node

Interface
REQ-001 SHALL have parameter PAYLOAD, 32, payload bits per packet.
REQ-002 SHALL have parameters X_BITS, 1 and Y_BITS, 1, destination x/y field widths; packet_size = X_BITS+Y_BITS+PAYLOAD, header {x,y} in the MSBs.
REQ-003 SHALL have parameter CNT_W, 16, width of all packet counters.
REQ-004 SHALL have ports clk  in  1  clock, and rst  in  1  reset; one clock, reset synchronous and active-low.
REQ-005 SHALL have ports start  in  1  burst start pulse; mode  in  2  destination mode; fixed_dst  in  X_BITS+Y_BITS  fixed destination.
REQ-006 SHALL have ports pkt_count  in  CNT_W  packets per burst; gap  in  8  idle cycles between packets; my_addr  in  X_BITS+Y_BITS  own node address.
REQ-007 SHALL have TX ports req_o  out  1  2-phase request; data_o  out  packet_size  packet; ack_i  in  1  2-phase acknowledge.
REQ-008 SHALL have RX ports req_i  in  1  2-phase request; data_i  in  packet_size  packet; ack_o  out  1  2-phase acknowledge.
REQ-009 SHALL have status ports busy  out  1; done  out  1  one-cycle pulse; tx_cnt, rx_cnt, err_cnt  out  CNT_W each; last_rx  out  packet_size.

Function
REQ-010 SHALL use 2-phase handshake: each req toggle is one packet; transfer complete when ack level equals req level.
REQ-011 TX FSM SHALL have states IDLE, SEND, WAIT_ACK, GAP.
REQ-012 IDLE: start=1 and pkt_count!=0 -> SEND, busy=1; start=1 and pkt_count=0 -> done pulse next cycle, no packet; start ignored while busy.
REQ-013 SEND: SHALL register data_o={dest, payload}, toggle req_o in the same cycle, -> WAIT_ACK; data_o SHALL stay stable until ack.
REQ-014 WAIT_ACK: when synchronised ack_i equals req_o, tx_cnt+1; if burst packets sent equals pkt_count -> IDLE with done=1, busy=0; else gap=0 -> SEND, else GAP.
REQ-015 GAP: SHALL count exactly gap idle cycles, then -> SEND.
REQ-016 payload SHALL be the burst sequence number (0,1,2,...) zero-extended or truncated to PAYLOAD.
REQ-017 mode 00 and 11: dest=fixed_dst; mode 01: dest starts at fixed_dst, +1 per packet, wraps modulo 2^(X_BITS+Y_BITS); mode 10: dest = low X_BITS+Y_BITS bits of LFSR.
REQ-018 LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1, advancing once per SEND.
REQ-019 RX: when synchronised req_i differs from ack_o, SHALL capture data_i into last_rx, rx_cnt+1, err_cnt+1 if header != my_addr, toggle ack_o in the same cycle.
REQ-020 RX and TX SHALL operate concurrently and independently.
REQ-021 tx_cnt, rx_cnt, err_cnt SHALL saturate at all-ones, not wrap; tx_cnt/rx_cnt/err_cnt are cumulative since reset, not cleared by start.

Reset
REQ-022 rst=0 at a clk edge SHALL set FSM IDLE, req_o=0, ack_o=0, data_o=0, last_rx=0, busy=0, done=0, all counters 0, LFSR=16'hACE1, synchroniser flops 0.
REQ-023 reset mid-burst SHALL abandon the in-flight packet; no done pulse; peers SHALL be reset together.

Configuration
REQ-024 macro NOC_TRAFFIC_SYNC_EN defined: ack_i and req_i SHALL each pass a 2-flop synchroniser; req_i toggle to ack_o toggle = 3 clk edges.
REQ-025 macro NOC_TRAFFIC_SYNC_EN undefined: ack_i/req_i used directly; req_i toggle to ack_o toggle = 1 clk edge; port list identical.

Verification
REQ-026 Loopback req_o->req_i, data_o->data_i, ack_o->ack_i, my_addr=2'b01, mode 00, fixed_dst=2'b01, pkt_count=4, gap=0 -> 4 packets payload 0..3, tx_cnt=rx_cnt=4, err_cnt=0, one done pulse.
REQ-027 Same loopback, my_addr=2'b00, mode 01, fixed_dst=2'b11, pkt_count=4 -> headers 11,00,01,10; err_cnt=3.
REQ-028 gap=5, pkt_count=2, responder acks after 1 cycle -> exactly 5 cycles with req_o stable between ack of packet 0 and toggle of packet 1.
REQ-029 pkt_count=0 start -> no req_o toggle, done pulses once, busy stays 0; second start while busy -> ignored, burst length unchanged.
REQ-030 rst=0 asserted in WAIT_ACK of packet 2 -> all outputs at reset values next edge; new start after release sends payload 0 from LFSR seed 16'hACE1.
REQ-031 With and without NOC_TRAFFIC_SYNC_EN, single req_i toggle -> ack_o toggles after 3 resp. 1 clk edges; rx_cnt=1.
